// File: rtl/cache_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single 16B memory port.
// Responses are steered back using an in-order queue of issued requester IDs.
module cache_mem_arbiter #(
    parameter int p_depth = 4
) (
    input  logic         clk,
    input  logic         reset,

    input  logic [174:0] req0_msg,
    input  logic         req0_val,
    output logic         req0_rdy,
    output logic [144:0] resp0_msg,
    output logic         resp0_val,
    input  logic         resp0_rdy,

    input  logic [174:0] req1_msg,
    input  logic         req1_val,
    output logic         req1_rdy,
    output logic [144:0] resp1_msg,
    output logic         resp1_val,
    input  logic         resp1_rdy,

    output logic [174:0] mem_req_msg,
    output logic         mem_req_val,
    input  logic         mem_req_rdy,
    input  logic [144:0] mem_resp_msg,
    input  logic         mem_resp_val,
    output logic         mem_resp_rdy
);

    localparam int PW = $clog2(p_depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LP_FULL = CW'(p_depth);

    logic               r_prio;
    logic               r_lock;
    logic               r_lock_id;
    logic [p_depth-1:0] r_queue;
    logic [PW-1:0]      r_enq_ptr;
    logic [PW-1:0]      r_deq_ptr;
    logic [CW-1:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_grant_val;
    logic w_grant;
    logic w_head;
    logic w_resp_en;
    logic w_req_fire;
    logic w_resp_fire;

    assign w_full  = (r_count == LP_FULL);
    assign w_empty = (r_count == '0);

    // Outputs are held quiet while reset is asserted so nothing fires into stale state.
    always_comb begin
        w_grant_val = 1'b0;
        w_grant     = 1'b0;
        if (!reset && !w_full) begin
            if (r_lock) begin
                w_grant_val = 1'b1;
                w_grant     = r_lock_id;
            end else if (req0_val && req1_val) begin
                w_grant_val = 1'b1;
                w_grant     = r_prio;
            end else if (req0_val) begin
                w_grant_val = 1'b1;
                w_grant     = 1'b0;
            end else if (req1_val) begin
                w_grant_val = 1'b1;
                w_grant     = 1'b1;
            end
        end
    end

    assign mem_req_msg = !w_grant_val ? '0 : (w_grant ? req1_msg : req0_msg);
    assign mem_req_val = w_grant_val && (w_grant ? req1_val : req0_val);
    assign req0_rdy    = w_grant_val && !w_grant && mem_req_rdy;
    assign req1_rdy    = w_grant_val &&  w_grant && mem_req_rdy;

    assign w_head    = r_queue[r_deq_ptr];
    assign w_resp_en = !reset && !w_empty;

    assign resp0_val    = w_resp_en && !w_head && mem_resp_val;
    assign resp1_val    = w_resp_en &&  w_head && mem_resp_val;
    assign resp0_msg    = (w_resp_en && !w_head) ? mem_resp_msg : '0;
    assign resp1_msg    = (w_resp_en &&  w_head) ? mem_resp_msg : '0;
    assign mem_resp_rdy = w_resp_en && (w_head ? resp1_rdy : resp0_rdy);

    assign w_req_fire  = mem_req_val && mem_req_rdy;
    assign w_resp_fire = mem_resp_val && mem_resp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio    <= 1'b0;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_queue   <= '0;
            r_enq_ptr <= '0;
            r_deq_ptr <= '0;
            r_count   <= '0;
        end else begin
            // Lock pins the stalled grant so the memory-side message stays stable.
            if (mem_req_val && !mem_req_rdy) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_grant;
            end
            if (w_req_fire) begin
                r_lock             <= 1'b0;
                r_prio             <= ~w_grant;
                r_queue[r_enq_ptr] <= w_grant;
                r_enq_ptr          <= r_enq_ptr + PW'(1);
            end
            if (w_resp_fire) begin
                r_deq_ptr <= r_deq_ptr + PW'(1);
            end
            case ({w_req_fire, w_resp_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_resp_when_empty: assert property (
        @(posedge clk) disable iff (reset) !(mem_resp_val && w_empty)
    ) else $error("memory response arrived with empty ID queue");

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: single request, contention, stall lock,
// full queue, response backpressure and mid-stream reset.
module tb_cache_mem_arbiter;

    logic         clk;
    logic         reset;
    logic [174:0] req0_msg, req1_msg, mem_req_msg;
    logic         req0_val, req0_rdy, req1_val, req1_rdy;
    logic [144:0] resp0_msg, resp1_msg, mem_resp_msg;
    logic         resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic         mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;

    int checks;
    int errors;

    cache_mem_arbiter #(.p_depth(4)) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [174:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                            input logic [31:0] addr, input logic [127:0] data);
        return {t, op, addr, 4'd0, data};
    endfunction

    function automatic logic [144:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                             input logic [127:0] data);
        return {t, op, 2'd0, 4'd0, data};
    endfunction

    task automatic chk(input string tag, input logic [174:0] obs, input logic [174:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        req0_val = 0; req1_val = 0; mem_req_rdy = 0; mem_resp_val = 0;
        resp0_rdy = 0; resp1_rdy = 0;
        req0_msg = '0; req1_msg = '0; mem_resp_msg = '0;
    endtask

    logic [174:0] r0, ra, rb;
    logic [144:0] p0, pr;
    logic         g, h;

    initial begin
        checks = 0;
        errors = 0;
        r0 = mk_req(3'd0, 8'h11, 32'h0000_1000, 128'h0);
        ra = mk_req(3'd0, 8'h21, 32'h0000_2000, 128'h0);
        rb = mk_req(3'd1, 8'h32, 32'h0000_3000, 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa);
        p0 = mk_resp(3'd0, 8'h11, 128'hAB);

        // Reset cycle: nothing may fire even with valid stimulus present
        reset = 1;
        idle_inputs();
        tick();
        req0_val = 1; req0_msg = r0; mem_req_rdy = 1;
        mem_resp_val = 1; mem_resp_msg = p0; resp0_rdy = 1;
        settle();
        chk("rst_mem_req_val", mem_req_val, 0);
        chk("rst_req0_rdy", req0_rdy, 0);
        chk("rst_resp0_val", resp0_val, 0);
        chk("rst_mem_resp_rdy", mem_resp_rdy, 0);
        tick();
        reset = 0;
        idle_inputs();
        settle();
        chk("rst_count", dut.r_count, 0);
        chk("rst_prio", dut.r_prio, 0);
        chk("rst_lock", dut.r_lock, 0);
        chk("rst_mem_req_val_after", mem_req_val, 0);
        tick();

        // Single requester read, response two cycles later
        req0_val = 1; req0_msg = r0; mem_req_rdy = 1;
        settle();
        chk("t1_mem_req_val", mem_req_val, 1);
        chk("t1_mem_req_msg", mem_req_msg, r0);
        chk("t1_req0_rdy", req0_rdy, 1);
        chk("t1_req1_rdy", req1_rdy, 0);
        tick();
        req0_val = 0;
        settle();
        chk("t1_count", dut.r_count, 1);
        chk("t1_idle_msg", mem_req_msg, 0);
        tick();
        mem_resp_val = 1; mem_resp_msg = p0; resp0_rdy = 1; resp1_rdy = 1;
        settle();
        chk("t1_resp0_val", resp0_val, 1);
        chk("t1_resp0_msg", resp0_msg, p0);
        chk("t1_resp1_val", resp1_val, 0);
        chk("t1_resp1_msg", resp1_msg, 0);
        chk("t1_mem_resp_rdy", mem_resp_rdy, 1);
        tick();
        mem_resp_val = 0;
        settle();
        chk("t1_count_drained", dut.r_count, 0);

        // Contention from prio=0: grants alternate, responses follow one cycle behind
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        req0_msg = ra; req1_msg = rb;
        for (int i = 0; i < 9; i++) begin
            req0_val = (i < 8); req1_val = (i < 8); mem_req_rdy = 1;
            resp0_rdy = 1; resp1_rdy = 1;
            mem_resp_val = (i > 0);
            mem_resp_msg = mk_resp(3'd0, 8'(i), 128'(i + 16'h100));
            g = 1'(i % 2);
            h = 1'((i + 1) % 2);
            settle();
            if (i < 8) begin
                chk($sformatf("t2_msg_%0d", i), mem_req_msg, g ? rb : ra);
                chk($sformatf("t2_req0_rdy_%0d", i), req0_rdy, !g);
                chk($sformatf("t2_req1_rdy_%0d", i), req1_rdy, g);
            end
            if (i > 0) begin
                chk($sformatf("t2_resp0_val_%0d", i), resp0_val, !h);
                chk($sformatf("t2_resp1_val_%0d", i), resp1_val, h);
            end
            tick();
        end
        idle_inputs();
        settle();
        chk("t2_count", dut.r_count, 0);
        chk("t2_prio", dut.r_prio, 0);

        // Stall lock: req1 granted, req0 arrives while memory stalls
        req0_msg = ra; req1_msg = rb;
        req1_val = 1; mem_req_rdy = 0;
        settle();
        chk("t3_c1_msg", mem_req_msg, rb);
        chk("t3_c1_val", mem_req_val, 1);
        tick();
        req0_val = 1;
        settle();
        chk("t3_c2_msg", mem_req_msg, rb);
        chk("t3_c2_req0_rdy", req0_rdy, 0);
        tick();
        settle();
        chk("t3_c3_msg", mem_req_msg, rb);
        tick();
        mem_req_rdy = 1;
        settle();
        chk("t3_c4_msg", mem_req_msg, rb);
        chk("t3_c4_req1_rdy", req1_rdy, 1);
        chk("t3_c4_req0_rdy", req0_rdy, 0);
        tick();
        settle();
        chk("t3_c5_msg", mem_req_msg, ra);
        chk("t3_c5_req0_rdy", req0_rdy, 1);
        tick();
        idle_inputs();
        settle();
        chk("t3_count", dut.r_count, 2);

        // Response backpressure on head=1
        mem_resp_val = 1; mem_resp_msg = p0; resp0_rdy = 1; resp1_rdy = 0;
        settle();
        chk("t5_mem_resp_rdy_blk", mem_resp_rdy, 0);
        chk("t5_resp0_val", resp0_val, 0);
        chk("t5_resp1_val", resp1_val, 1);
        tick();
        settle();
        chk("t5_deq_hold", dut.r_deq_ptr, 0);
        resp1_rdy = 1;
        settle();
        chk("t5_mem_resp_rdy", mem_resp_rdy, 1);
        tick();
        settle();
        chk("t5_deq_adv", dut.r_deq_ptr, 1);
        chk("t5_resp0_next", resp0_val, 1);
        tick();
        idle_inputs();
        settle();
        chk("t5_count", dut.r_count, 0);

        // Full queue: four req0 requests, prio ends at 1
        req0_msg = ra; req1_msg = rb;
        for (int i = 0; i < 4; i++) begin
            req0_val = 1; mem_req_rdy = 1;
            settle();
            chk($sformatf("t4_fill_%0d", i), mem_req_val, 1);
            tick();
        end
        req1_val = 1;
        settle();
        chk("t4_full_count", dut.r_count, 4);
        chk("t4_full_val", mem_req_val, 0);
        chk("t4_full_req0_rdy", req0_rdy, 0);
        chk("t4_full_req1_rdy", req1_rdy, 0);
        mem_resp_val = 1; mem_resp_msg = p0; resp0_rdy = 1; resp1_rdy = 1;
        settle();
        chk("t4_full_deq_val", mem_req_val, 0);
        chk("t4_full_deq_rdy", mem_resp_rdy, 1);
        tick();
        settle();
        chk("t4_count3", dut.r_count, 3);
        chk("t4_fifth_val", mem_req_val, 1);
        chk("t4_fifth_msg", mem_req_msg, rb);
        chk("t4_fifth_req1_rdy", req1_rdy, 1);
        chk("t4_enqdeq_resp_rdy", mem_resp_rdy, 1);
        tick();
        req0_val = 0; req1_val = 0;
        settle();
        chk("t4_count_hold", dut.r_count, 3);

        // Drain two, issue one more, then reset mid-stream
        pr = mk_resp(3'd0, 8'h77, 128'h77);
        mem_resp_msg = pr;
        settle();
        chk("t6_drain0", resp0_val, 1);
        tick();
        settle();
        chk("t6_drain1", resp0_val, 1);
        tick();
        mem_resp_val = 0;
        req0_val = 1;
        settle();
        chk("t6_req0_issue", req0_rdy, 1);
        tick();
        idle_inputs();
        settle();
        chk("t6_pre_count", dut.r_count, 2);
        chk("t6_pre_prio", dut.r_prio, 1);
        reset = 1;
        tick();
        reset = 0;
        settle();
        chk("t6_count", dut.r_count, 0);
        chk("t6_prio", dut.r_prio, 0);
        req1_val = 1; req1_msg = rb; mem_req_rdy = 1;
        settle();
        chk("t6_req1_val", mem_req_val, 1);
        chk("t6_req1_msg", mem_req_msg, rb);
        chk("t6_req1_rdy", req1_rdy, 1);
        tick();
        idle_inputs();
        mem_resp_val = 1; mem_resp_msg = pr; resp0_rdy = 1; resp1_rdy = 1;
        settle();
        chk("t6_resp1_val", resp1_val, 1);
        chk("t6_resp0_val", resp0_val, 0);
        tick();
        idle_inputs();
        settle();
        chk("t6_final_count", dut.r_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
